// File: rtl/pipelined_adder.sv
// Pipelined N-bit add/subtract: the carry chain is cut into STAGES segments, one register per segment.
// Define PIPELINED_ADDER_FLAGS_EN to add the V (signed overflow) and Z (zero) outputs.
module pipelined_adder #(
    parameter int unsigned N      = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_in,
    output logic         ready_in,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    input  logic         Sub,
    output logic         valid_out,
    input  logic         ready_out,
    output logic [N-1:0] S,
    output logic         Cout
`ifdef PIPELINED_ADDER_FLAGS_EN
   ,output logic         V,
    output logic         Z
`endif
);
    localparam int unsigned SDIV = (STAGES == 0) ? 1 : STAGES;
    localparam int unsigned W    = N / SDIV;

    if (STAGES < 1 || STAGES > N || (N % SDIV) != 0) begin : g_bad_cfg
        $error("pipelined_adder: STAGES must be in 1..N and divide N");
    end

    logic [N-1:0]      a_r   [STAGES];
    logic [N-1:0]      b_r   [STAGES];
    logic [N-1:0]      s_r   [STAGES];
    logic [N-1:0]      s_nxt [STAGES];
    logic [W:0]        seg   [STAGES];
    logic [STAGES-1:0] c_r;
    logic [STAGES-1:0] v_r;
    logic [N-1:0]      bx;
    logic              cin0;
    logic              en;

    assign en       = ready_out | ~valid_out;
    assign ready_in = en;

    // Each stage adds its own slice; earlier sum slices ride along unchanged.
    always_comb begin
        bx       = Sub ? ~B : B;
        cin0     = Sub | Cin;
        seg[0]   = {1'b0, A[W-1:0]} + {1'b0, bx[W-1:0]} + {{W{1'b0}}, cin0};
        s_nxt[0] = '0;
        s_nxt[0][W-1:0] = seg[0][W-1:0];
        for (int unsigned k = 1; k < STAGES; k++) begin
            seg[k]   = {1'b0, a_r[k-1][k*W +: W]} + {1'b0, b_r[k-1][k*W +: W]}
                     + {{W{1'b0}}, c_r[k-1]};
            s_nxt[k] = s_r[k-1];
            s_nxt[k][k*W +: W] = seg[k][W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_r <= '0;
        end else if (en) begin
            v_r[0] <= valid_in;
            for (int unsigned k = 1; k < STAGES; k++) begin
                v_r[k] <= v_r[k-1];
            end
        end
    end

    // Data registers carry no reset; they are qualified by the valid bits.
    always_ff @(posedge clk) begin
        if (en) begin
            a_r[0] <= A;
            b_r[0] <= bx;
            s_r[0] <= s_nxt[0];
            c_r[0] <= seg[0][W];
            for (int unsigned k = 1; k < STAGES; k++) begin
                a_r[k] <= a_r[k-1];
                b_r[k] <= b_r[k-1];
                s_r[k] <= s_nxt[k];
                c_r[k] <= seg[k][W];
            end
        end
    end

    assign valid_out = v_r[STAGES-1];
    assign S         = s_r[STAGES-1];
    assign Cout      = c_r[STAGES-1];

`ifdef PIPELINED_ADDER_FLAGS_EN
    // Carry into the MSB is recovered from the MSB sum bit and its operands.
    assign V = (s_r[STAGES-1][N-1] ^ a_r[STAGES-1][N-1] ^ b_r[STAGES-1][N-1]) ^ c_r[STAGES-1];
    assign Z = ~|s_r[STAGES-1];
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed table, random stream with backpressure,
// mid-flight reset; STAGES=4 main instance plus STAGES=1 and STAGES=32 instances.
module tb_pipelined_adder;
    localparam int unsigned N  = 32;
    localparam int unsigned S0 = 4;
    localparam int unsigned S1 = 1;
    localparam int unsigned S2 = 32;

    typedef struct {
        logic [31:0] a, b;
        logic        cin, sub;
    } op_t;

    typedef struct {
        logic [31:0] a, b;
        logic        cin, sub;
        int unsigned c;
    } rec_t;

    typedef struct {
        logic [31:0] a, b;
        logic        cin, sub;
        logic [31:0] s;
        logic        co, v, z;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, valid_in, ready_out, Cin, Sub;
    logic [31:0] A, B;
    logic [2:0]  rin, vout, cout, rdy_o;
    logic [31:0] s [3];
    logic        aux_valid;
`ifdef PIPELINED_ADDER_FLAGS_EN
    logic [2:0]  vf, zf;
`endif

    int unsigned n_pass = 0, n_total = 0, cyc = 0;
    int unsigned rd [3];
    bit          lat_chk = 1'b0;
    rec_t        q [$];

    always #5 clk = ~clk;

    assign aux_valid = valid_in & rin[0];
    assign rdy_o     = {2'b11, ready_out};

    pipelined_adder #(.N(N), .STAGES(S0)) u_s4 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(rin[0]),
        .A(A), .B(B), .Cin(Cin), .Sub(Sub),
        .valid_out(vout[0]), .ready_out(ready_out), .S(s[0]), .Cout(cout[0])
`ifdef PIPELINED_ADDER_FLAGS_EN
       ,.V(vf[0]), .Z(zf[0])
`endif
    );

    pipelined_adder #(.N(N), .STAGES(S1)) u_s1 (
        .clk(clk), .rst(rst), .valid_in(aux_valid), .ready_in(rin[1]),
        .A(A), .B(B), .Cin(Cin), .Sub(Sub),
        .valid_out(vout[1]), .ready_out(1'b1), .S(s[1]), .Cout(cout[1])
`ifdef PIPELINED_ADDER_FLAGS_EN
       ,.V(vf[1]), .Z(zf[1])
`endif
    );

    pipelined_adder #(.N(N), .STAGES(S2)) u_s32 (
        .clk(clk), .rst(rst), .valid_in(aux_valid), .ready_in(rin[2]),
        .A(A), .B(B), .Cin(Cin), .Sub(Sub),
        .valid_out(vout[2]), .ready_out(1'b1), .S(s[2]), .Cout(cout[2])
`ifdef PIPELINED_ADDER_FLAGS_EN
       ,.V(vf[2]), .Z(zf[2])
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    endtask

    // Reference: plain (N+1)-bit arithmetic and signed-range overflow.
    function automatic logic [32:0] ref_sum(input logic [31:0] a, input logic [31:0] b,
                                            input logic cin, input logic sub);
        if (sub) return {1'b0, a} + {1'b0, ~b} + 33'd1;
        return {1'b0, a} + {1'b0, b} + {32'd0, cin};
    endfunction

    function automatic logic ref_ovf(input logic [31:0] a, input logic [31:0] b,
                                     input logic cin, input logic sub);
        longint t;
        if (sub) t = longint'(signed'(a)) - longint'(signed'(b));
        else     t = longint'(signed'(a)) + longint'(signed'(b)) + longint'(cin);
        return (t > 64'sd2147483647) || (t < -64'sd2147483648);
    endfunction

    function automatic int unsigned stg_of(input int i);
        return (i == 0) ? S0 : (i == 1) ? S1 : S2;
    endfunction

    // Scoreboard: every op accepted by the main instance is expected in order from all three.
    always @(negedge clk) begin
        logic [32:0] e;
        cyc++;
        if (rst) begin
            q.delete();
            rd = '{0, 0, 0};
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (vout[i] && rdy_o[i]) begin
                    if (rd[i] >= q.size()) begin
                        chk($sformatf("sb%0d_extra_output", i), 64'd1, 64'd0);
                    end else begin
                        e = ref_sum(q[rd[i]].a, q[rd[i]].b, q[rd[i]].cin, q[rd[i]].sub);
                        chk($sformatf("sb%0d_result", i), {31'd0, cout[i], s[i]}, {31'd0, e});
                        if (i != 0 || lat_chk)
                            chk($sformatf("sb%0d_latency", i), 64'(cyc - q[rd[i]].c), 64'(stg_of(i)));
`ifdef PIPELINED_ADDER_FLAGS_EN
                        chk($sformatf("sb%0d_V", i), 64'(vf[i]),
                            64'(ref_ovf(q[rd[i]].a, q[rd[i]].b, q[rd[i]].cin, q[rd[i]].sub)));
                        chk($sformatf("sb%0d_Z", i), 64'(zf[i]), 64'(e[31:0] == 32'd0));
`endif
                        rd[i]++;
                    end
                end
            end
            if (valid_in && rin[0]) q.push_back('{A, B, Cin, Sub, cyc});
        end
    end

    task automatic drive(input op_t o);
        A = o.a; B = o.b; Cin = o.cin; Sub = o.sub;
    endtask

    task automatic send_one(input vec_t v, input string nm);
        int unsigned lat;
        @(posedge clk); #1;
        A = v.a; B = v.b; Cin = v.cin; Sub = v.sub; valid_in = 1'b1; ready_out = 1'b1;
        @(negedge clk);
        chk({nm, "_accept"}, 64'(rin[0]), 64'd1);
        @(posedge clk); #1;
        valid_in = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!vout[0] && lat < 100);
        chk({nm, "_latency"}, 64'(lat), 64'(S0));
        chk({nm, "_S"}, 64'(s[0]), 64'(v.s));
        chk({nm, "_Cout"}, 64'(cout[0]), 64'(v.co));
`ifdef PIPELINED_ADDER_FLAGS_EN
        chk({nm, "_V"}, 64'(vf[0]), 64'(v.v));
        chk({nm, "_Z"}, 64'(zf[0]), 64'(v.z));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [10];
        op_t         ops [$];
        op_t         o;
        int unsigned idx, guard, q0, cnt;
        logic        acc, stalled, hc;
        logic [31:0] hs;
        localparam int unsigned NOPS = 100;

        tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        tbl[1] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0, 1'b0};
        tbl[8] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        tbl[9] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};

        rst = 1'b1; valid_in = 1'b0; ready_out = 1'b0;
        A = '0; B = '0; Cin = 1'b0; Sub = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_valid_out", 64'(vout), 64'd0);
        chk("reset_ready_in", 64'(rin), 64'd7);
        @(posedge clk); #1;
        rst = 1'b0;

        lat_chk = 1'b1;
        for (int i = 0; i < 10; i++) send_one(tbl[i], $sformatf("vec%0d", i));

        // Every segment boundary (and every bit boundary, for STAGES=32) sees a carry.
        for (int unsigned k = 1; k < 32; k++) begin
            o.a = (32'h1 << k) - 32'h1; o.b = 32'h1; o.cin = 1'b0; o.sub = 1'b0;
            ops.push_back(o);
        end
        while (ops.size() < NOPS) begin
            o.a = $urandom; o.b = $urandom;
            o.cin = 1'($urandom_range(0, 1)); o.sub = 1'($urandom_range(0, 1));
            ops.push_back(o);
        end

        lat_chk = 1'b0;
        q0 = q.size();
        idx = 0; guard = 0; stalled = 1'b0;
        @(posedge clk); #1;
        ready_out = 1'b1; drive(ops[0]); valid_in = 1'b1;
        while (idx < NOPS && guard < 3000) begin
            @(negedge clk);
            acc = valid_in && rin[0];
            @(posedge clk); #1;
            guard++;
            if (acc) begin
                idx++;
                if (idx < NOPS) drive(ops[idx]);
                else valid_in = 1'b0;
            end
            if (idx == 40 && !stalled) begin
                stalled = 1'b1;
                ready_out = 1'b0;
                for (int j = 0; j < 5; j++) begin
                    @(negedge clk);
                    chk("bp_ready_in", 64'(rin[0]), 64'd0);
                    chk("bp_valid_out", 64'(vout[0]), 64'd1);
                    if (j == 0) begin
                        hs = s[0]; hc = cout[0];
                    end else begin
                        chk("bp_S_stable", 64'(s[0]), 64'(hs));
                        chk("bp_Cout_stable", 64'(cout[0]), 64'(hc));
                    end
                    @(posedge clk); #1;
                end
                ready_out = 1'b1;
            end
        end
        chk("stream_no_timeout", 64'(idx), 64'(NOPS));
        valid_in = 1'b0;
        guard = 0;
        while ((rd[0] != q.size() || rd[1] != q.size() || rd[2] != q.size()) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("stream_accepted", 64'(q.size() - q0), 64'(NOPS));
        for (int i = 0; i < 3; i++)
            chk($sformatf("drain%0d_count", i), 64'(rd[i]), 64'(q.size()));

        // Three ops in flight, then a one-cycle reset must discard them all.
        @(posedge clk); #1;
        valid_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(ops[i]);
            @(posedge clk); #1;
        end
        valid_in = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (vout != 3'b000) cnt++;
        end
        chk("rst_no_stale_valid", 64'(cnt), 64'd0);
        chk("rst_ready_in", 64'(rin), 64'd7);
        lat_chk = 1'b1;
        send_one(tbl[3], "post_rst");
        repeat (40) @(negedge clk);
        for (int i = 0; i < 3; i++)
            chk($sformatf("post_rst%0d_count", i), 64'(rd[i]), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
